// File: rtl/bali_arb_pkg.sv
// Shared types and helpers for the bali round-robin arbiter.
// Holds the FSM state type, the NUM_REQ legality check and the one-hot encoder.
package bali_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic bit num_req_legal(input int n);
        return (n == 4) || (n == 8) || (n == 16) || (n == 32);
    endfunction

    // One-hot to binary for up to 32 lanes; callers zero-extend and truncate.
    function automatic logic [4:0] onehot_enc(input logic [31:0] oh);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                r = r | 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bali_rr_arb_if.sv
// Request/grant bundle between the DMA channels, the consumer and the arbiter.
// master = requester/consumer side, slave = arbiter side.
interface bali_rr_arb_if #(
    parameter int NUM_REQ = 16
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_en;
    logic               gnt_done;
    logic               gnt_vld;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IDX_W-1:0]   gnt_idx;
    logic               err_done_idle;

    modport master (
        output req, req_en, gnt_done,
        input  gnt_vld, gnt_onehot, gnt_idx, err_done_idle
    );

    modport slave (
        input  req, req_en, gnt_done,
        output gnt_vld, gnt_onehot, gnt_idx, err_done_idle
    );
endinterface

// File: rtl/bali_rr_pick.sv
// Rotating priority pick: first set bit of eff at or above ptr, wrapping.
// Rotate down by ptr, isolate lowest set bit, rotate back up.
module bali_rr_pick #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eff,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick
);
    logic [2*NUM_REQ-1:0] dn;
    logic [2*NUM_REQ-1:0] up;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   iso;

    // Rotate so ptr lands on bit 0, keep the lowest request, undo the rotation.
    always_comb begin
        dn   = {eff, eff} >> ptr;
        rot  = dn[NUM_REQ-1:0];
        iso  = rot & (~rot + NUM_REQ'(1));
        up   = {iso, iso} << ptr;
        pick = up[2*NUM_REQ-1:NUM_REQ];
    end
endmodule

// File: rtl/bali_rr_arb.sv
// Round-robin arbiter for the PCIe application DMA/request channels.
// Registered one-hot grant plus index, held until gnt_done, then rotate.
module bali_rr_arb
    import bali_arb_pkg::*;
#(
    parameter int  NUM_REQ = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    bali_rr_arb_if.slave  bus
);
    if (!num_req_legal(NUM_REQ)) begin : g_bad_num_req
        $error("bali_rr_arb: NUM_REQ must be 4, 8, 16 or 32");
    end

    arb_state_t         state_q, state_n;
    logic [IDX_W-1:0]   ptr_q, ptr_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [IDX_W-1:0]   pick_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] oh_q, oh_n;
    logic [NUM_REQ-1:0] eff;
    logic [NUM_REQ-1:0] pick;
    logic               err_q, err_n;

    assign eff = bus.req & bus.req_en;

    // Finishing a grant re-arbitrates in the same cycle from the advanced pointer.
    assign pick_ptr = (state_q == GRANT && bus.gnt_done) ? idx_q + IDX_W'(1) : ptr_q;

    bali_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .eff  (eff),
        .ptr  (pick_ptr),
        .pick (pick)
    );

    assign pick_idx = IDX_W'(onehot_enc(32'(pick)));

    // Next-state: grant from IDLE, hold in GRANT, chain or release on gnt_done.
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        oh_n    = oh_q;
        idx_n   = idx_q;
        err_n   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.gnt_done) begin
                    err_n = 1'b1;
                end
                if (|eff) begin
                    oh_n    = pick;
                    idx_n   = pick_idx;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (bus.gnt_done) begin
                    ptr_n = pick_ptr;
                    if (|eff) begin
                        oh_n  = pick;
                        idx_n = pick_idx;
                    end else begin
                        oh_n    = '0;
                        idx_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
        endcase
    end

    // State, pointer, grant and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            oh_q    <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            oh_q    <= oh_n;
            idx_q   <= idx_n;
            err_q   <= err_n;
        end
    end

    assign bus.gnt_vld       = (state_q == GRANT);
    assign bus.gnt_onehot    = oh_q;
    assign bus.gnt_idx       = idx_q;
    assign bus.err_done_idle = err_q;

    a_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(oh_q));

    a_idx_match: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == GRANT) |-> (oh_q == (NUM_REQ'(1) << idx_q)));
endmodule

// File: tb/tb_bali_rr_arb.sv
// Directed testbench for bali_rr_arb (NUM_REQ=16).
// Inputs driven and outputs sampled on the falling edge.
module tb_bali_rr_arb;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bali_rr_arb_if #(.NUM_REQ(16)) bus ();

    bali_rr_arb #(.NUM_REQ(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        bus.req      = '0;
        bus.req_en   = 16'hFFFF;
        bus.gnt_done = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_done(input logic [15:0] new_req);
        bus.req      = new_req;
        bus.gnt_done = 1'b1;
        @(negedge clk);
        bus.gnt_done = 1'b0;
    endtask

    task automatic test_reset();
        bus.req      = '0;
        bus.req_en   = 16'hFFFF;
        bus.gnt_done = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.gnt_vld !== 1'b0) begin
            failures++; $display("FAIL reset_vld got=%b exp=0", bus.gnt_vld);
        end
        checks++;
        if (bus.gnt_onehot !== 16'h0) begin
            failures++; $display("FAIL reset_onehot got=%h exp=0000", bus.gnt_onehot);
        end
        checks++;
        if (bus.gnt_idx !== 4'd0) begin
            failures++; $display("FAIL reset_idx got=%0d exp=0", bus.gnt_idx);
        end
        checks++;
        if (bus.err_done_idle !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b exp=0", bus.err_done_idle);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 16'h0001;
        @(negedge clk);
        checks++;
        if (bus.gnt_vld !== 1'b1 || bus.gnt_onehot !== 16'h0001 || bus.gnt_idx !== 4'd0) begin
            failures++;
            $display("FAIL single_grant got vld=%b oh=%h idx=%0d exp vld=1 oh=0001 idx=0",
                     bus.gnt_vld, bus.gnt_onehot, bus.gnt_idx);
        end
        pulse_done(16'h0000);
        checks++;
        if (bus.gnt_vld !== 1'b0 || bus.gnt_onehot !== 16'h0 || bus.gnt_idx !== 4'd0) begin
            failures++;
            $display("FAIL single_release got vld=%b oh=%h idx=%0d exp vld=0 oh=0000 idx=0",
                     bus.gnt_vld, bus.gnt_onehot, bus.gnt_idx);
        end
        bus.req = 16'h0003;
        @(negedge clk);
        checks++;
        if (bus.gnt_idx !== 4'd1 || bus.gnt_vld !== 1'b1) begin
            failures++;
            $display("FAIL single_ptr1 got idx=%0d vld=%b exp idx=1 vld=1", bus.gnt_idx, bus.gnt_vld);
        end
        pulse_done(16'h0000);
    endtask

    task automatic test_rotate();
        logic [3:0]  e;
        logic [15:0] eo;
        do_reset();
        bus.req = 16'hFFFF;
        @(negedge clk);
        for (int k = 0; k <= 16; k++) begin
            e  = 4'(k % 16);
            eo = 16'h0001 << e;
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== e || bus.gnt_onehot !== eo) begin
                    failures++;
                    $display("FAIL rotate k=%0d c=%0d got vld=%b idx=%0d oh=%h exp vld=1 idx=%0d oh=%h",
                             k, c, bus.gnt_vld, bus.gnt_idx, bus.gnt_onehot, e, eo);
                end
                if (c == 2 && k < 16) begin
                    bus.gnt_done = 1'b1;
                end
                if (c < 2 || k < 16) begin
                    @(negedge clk);
                end
                bus.gnt_done = 1'b0;
            end
        end
        pulse_done(16'h0000);
        checks++;
        if (bus.gnt_vld !== 1'b0) begin
            failures++; $display("FAIL rotate_end_vld got=%b exp=0", bus.gnt_vld);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req = 16'h8000;
        @(negedge clk);
        checks++;
        if (bus.gnt_idx !== 4'd15 || bus.gnt_onehot !== 16'h8000) begin
            failures++;
            $display("FAIL wrap_first got idx=%0d oh=%h exp idx=15 oh=8000", bus.gnt_idx, bus.gnt_onehot);
        end
        pulse_done(16'h8001);
        checks++;
        if (bus.gnt_idx !== 4'd0 || bus.gnt_vld !== 1'b1) begin
            failures++;
            $display("FAIL wrap_to0 got idx=%0d vld=%b exp idx=0 vld=1", bus.gnt_idx, bus.gnt_vld);
        end
        pulse_done(16'h8000);
        checks++;
        if (bus.gnt_idx !== 4'd15 || bus.gnt_vld !== 1'b1) begin
            failures++;
            $display("FAIL wrap_regrant got idx=%0d vld=%b exp idx=15 vld=1", bus.gnt_idx, bus.gnt_vld);
        end
        pulse_done(16'h8000);
        checks++;
        if (bus.gnt_idx !== 4'd15 || bus.gnt_vld !== 1'b1) begin
            failures++;
            $display("FAIL wrap_only_req got idx=%0d vld=%b exp idx=15 vld=1", bus.gnt_idx, bus.gnt_vld);
        end
        pulse_done(16'h0000);
    endtask

    task automatic test_mask();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd5, 4'd7, 4'd5, 4'd7};
        do_reset();
        bus.req    = 16'h00F0;
        bus.req_en = 16'h00A0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.gnt_idx !== exp_seq[k] || bus.gnt_onehot !== (16'h0001 << exp_seq[k])) begin
                failures++;
                $display("FAIL mask k=%0d got idx=%0d oh=%h exp idx=%0d",
                         k, bus.gnt_idx, bus.gnt_onehot, exp_seq[k]);
            end
            if (k < 3) begin
                pulse_done(16'h00F0);
            end
        end
        bus.req_en = 16'hFFFF;
        pulse_done(16'h0000);
    endtask

    task automatic test_hold_err();
        do_reset();
        bus.req = 16'h0008;
        @(negedge clk);
        bus.req    = 16'h0000;
        bus.req_en = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 4'd3 || bus.gnt_onehot !== 16'h0008) begin
                failures++;
                $display("FAIL hold c=%0d got vld=%b idx=%0d oh=%h exp vld=1 idx=3 oh=0008",
                         c, bus.gnt_vld, bus.gnt_idx, bus.gnt_onehot);
            end
        end
        bus.req_en = 16'hFFFF;
        pulse_done(16'h0000);
        checks++;
        if (bus.gnt_vld !== 1'b0 || bus.err_done_idle !== 1'b0) begin
            failures++;
            $display("FAIL hold_release got vld=%b err=%b exp vld=0 err=0", bus.gnt_vld, bus.err_done_idle);
        end
        pulse_done(16'h0000);
        checks++;
        if (bus.err_done_idle !== 1'b1 || bus.gnt_vld !== 1'b0) begin
            failures++;
            $display("FAIL err_set got err=%b vld=%b exp err=1 vld=0", bus.err_done_idle, bus.gnt_vld);
        end
        bus.req = 16'h0001;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.err_done_idle !== 1'b1 || bus.gnt_idx !== 4'd0 || bus.gnt_vld !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got err=%b idx=%0d vld=%b exp err=1 idx=0 vld=1",
                     bus.err_done_idle, bus.gnt_idx, bus.gnt_vld);
        end
    endtask

    task automatic test_async_reset();
        bus.gnt_done = 1'b0;
        pulse_done(16'h0010);
        checks++;
        if (bus.gnt_idx !== 4'd4 || bus.gnt_vld !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre got idx=%0d vld=%b exp idx=4 vld=1", bus.gnt_idx, bus.gnt_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt_vld !== 1'b0 || bus.gnt_onehot !== 16'h0 || bus.gnt_idx !== 4'd0 ||
            bus.err_done_idle !== 1'b0) begin
            failures++;
            $display("FAIL arst_now got vld=%b oh=%h idx=%0d err=%b exp all 0",
                     bus.gnt_vld, bus.gnt_onehot, bus.gnt_idx, bus.err_done_idle);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 16'h0006;
        @(negedge clk);
        checks++;
        if (bus.gnt_idx !== 4'd1 || bus.gnt_onehot !== 16'h0002 || bus.gnt_vld !== 1'b1) begin
            failures++;
            $display("FAIL arst_after got idx=%0d oh=%h vld=%b exp idx=1 oh=0002 vld=1",
                     bus.gnt_idx, bus.gnt_onehot, bus.gnt_vld);
        end
        pulse_done(16'h0000);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req      = '0;
        bus.req_en   = 16'hFFFF;
        bus.gnt_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_rotate();
        test_wrap();
        test_mask();
        test_hold_err();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
